// File: rtl/drawing_de_arbiter_pkg.sv
// rtl/drawing_de_arbiter_pkg.sv - shared widths, FSM states and idle values for the drawing-engine arbiter
package drawing_de_pkg;

  localparam int DE_ADDR_W  = 18;
  localparam int DE_DATA_W  = 32;
  localparam int DE_NBYTE_W = 4;

  typedef enum logic {
    IDLE  = 1'b0,
    GRANT = 1'b1
  } arb_state_t;

  // Values presented to the frame store when nobody owns the port
  localparam logic [DE_ADDR_W-1:0]  DE_IDLE_ADDR   = '0;
  localparam logic [DE_NBYTE_W-1:0] DE_IDLE_NBYTE  = '1;
  localparam logic                  DE_IDLE_RNW    = 1'b1;
  localparam logic [DE_DATA_W-1:0]  DE_IDLE_W_DATA = '0;

endpackage

// File: rtl/drawing_de_arbiter_if.sv
// rtl/drawing_de_arbiter_if.sv - frame-store side de_* handshake bundle
interface drawing_de_if;
  import drawing_de_pkg::*;

  logic                  de_req;
  logic                  de_ack;
  logic [DE_ADDR_W-1:0]  de_addr;
  logic [DE_NBYTE_W-1:0] de_nbyte;
  logic                  de_rnw;
  logic [DE_DATA_W-1:0]  de_w_data;
  logic [DE_DATA_W-1:0]  de_r_data;

  modport master (
    output de_req, de_addr, de_nbyte, de_rnw, de_w_data,
    input  de_ack, de_r_data
  );

  modport slave (
    input  de_req, de_addr, de_nbyte, de_rnw, de_w_data,
    output de_ack, de_r_data
  );

endinterface

// File: rtl/drawing_de_arbiter_rr_pick.sv
// rtl/drawing_de_arbiter_rr_pick.sv - combinational round-robin selector starting at ptr
module rr_pick #(
  parameter int N  = 4,
  parameter int IW = $clog2(N)
) (
  input  logic [N-1:0]  req,
  input  logic [N-1:0]  mask,
  input  logic [IW-1:0] ptr,
  output logic [IW-1:0] winner,
  output logic          valid
);

  // Scan from ptr upward with wrap; first eligible requester wins
  always_comb begin
    int idx;
    idx    = 0;
    valid  = 1'b0;
    winner = '0;
    for (int k = 0; k < N; k++) begin
      idx = (int'(ptr) + k) % N;
      if (!valid && req[idx] && mask[idx]) begin
        valid  = 1'b1;
        winner = IW'(idx);
      end
    end
  end

endmodule

// File: rtl/drawing_de_arbiter.sv
// rtl/drawing_de_arbiter.sv - round-robin share of the frame-store port; DE_ARB_LOCK_EN enables busy lock
module drawing_de_arbiter
  import drawing_de_pkg::*;
#(
  parameter int NUM_REQ = 4
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic [NUM_REQ-1:0]              in_de_req,
  input  logic [NUM_REQ-1:0]              in_busy,
  input  logic [DE_ADDR_W*NUM_REQ-1:0]    in_de_addr,
  input  logic [DE_NBYTE_W*NUM_REQ-1:0]   in_de_nbyte,
  input  logic [NUM_REQ-1:0]              in_de_rnw,
  input  logic [DE_DATA_W*NUM_REQ-1:0]    in_de_w_data,
  output logic [NUM_REQ-1:0]              in_de_ack,
  output logic [DE_DATA_W-1:0]            in_de_r_data,
  drawing_de_if.master                    de
);

  localparam int IW = $clog2(NUM_REQ);

  arb_state_t      state, state_next;
  logic [IW-1:0]   owner;
  logic [IW-1:0]   ptr;
  logic [IW-1:0]   pick_idx;
  logic            pick_valid;
  logic [NUM_REQ-1:0] elig;

  logic [DE_ADDR_W-1:0]  addr_arr  [NUM_REQ];
  logic [DE_NBYTE_W-1:0] nbyte_arr [NUM_REQ];
  logic [DE_DATA_W-1:0]  wdata_arr [NUM_REQ];

  for (genvar g = 0; g < NUM_REQ; g++) begin : g_unpack
    assign addr_arr[g]  = in_de_addr[g*DE_ADDR_W +: DE_ADDR_W];
    assign nbyte_arr[g] = in_de_nbyte[g*DE_NBYTE_W +: DE_NBYTE_W];
    assign wdata_arr[g] = in_de_w_data[g*DE_DATA_W +: DE_DATA_W];
  end

  wire xfer_done = (state == GRANT) && de.de_ack;

`ifdef DE_ARB_LOCK_EN
  logic          lock_valid;
  logic [IW-1:0] lock_idx;

  // A held lock only restricts arbitration while its engine is still busy
  always_comb begin
    elig = '1;
    if (lock_valid && in_busy[lock_idx]) begin
      elig = '0;
      elig[lock_idx] = 1'b1;
    end
  end

  // Lock onto an engine whose transfer finished mid-operation; release when it goes idle
  always_ff @(posedge clk) begin
    if (rst) begin
      lock_valid <= 1'b0;
      lock_idx   <= '0;
    end else if (xfer_done && in_busy[owner]) begin
      lock_valid <= 1'b1;
      lock_idx   <= owner;
    end else if (lock_valid && !in_busy[lock_idx]) begin
      lock_valid <= 1'b0;
    end
  end
`else
  logic unused_busy;
  assign unused_busy = ^in_busy;

  // Without locking every requester is always eligible
  always_comb begin
    elig = '1;
  end
`endif

  rr_pick #(.N(NUM_REQ), .IW(IW)) u_rr_pick (
    .req    (in_de_req),
    .mask   (elig),
    .ptr    (ptr),
    .winner (pick_idx),
    .valid  (pick_valid)
  );

  // FSM state register
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  // Capture the winner on grant and advance the rotation pointer past it on completion
  always_ff @(posedge clk) begin
    if (rst) begin
      owner <= '0;
      ptr   <= '0;
    end else if (state == IDLE && pick_valid) begin
      owner <= pick_idx;
    end else if (xfer_done) begin
      ptr <= (owner == IW'(NUM_REQ - 1)) ? '0 : owner + 1'b1;
    end
  end

  // Next state plus frame-store mux; acks are suppressed while reset is applied
  always_comb begin
    state_next   = state;
    de.de_req    = 1'b0;
    de.de_addr   = DE_IDLE_ADDR;
    de.de_nbyte  = DE_IDLE_NBYTE;
    de.de_rnw    = DE_IDLE_RNW;
    de.de_w_data = DE_IDLE_W_DATA;
    in_de_ack    = '0;
    case (state)
      IDLE: begin
        if (pick_valid) state_next = GRANT;
      end
      GRANT: begin
        de.de_req    = in_de_req[owner];
        de.de_addr   = addr_arr[owner];
        de.de_nbyte  = nbyte_arr[owner];
        de.de_rnw    = in_de_rnw[owner];
        de.de_w_data = wdata_arr[owner];
        if (!rst) in_de_ack[owner] = de.de_ack;
        if (de.de_ack) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  assign in_de_r_data = de.de_r_data;

endmodule

// File: tb/tb_drawing_de_arbiter.sv
// tb/tb_drawing_de_arbiter.sv - directed self-checking bench for drawing_de_arbiter
module tb_drawing_de_arbiter;
  import drawing_de_pkg::*;

  localparam int NUM_REQ = 4;

  logic clk = 1'b0;
  logic rst;
  logic [NUM_REQ-1:0]            in_de_req;
  logic [NUM_REQ-1:0]            in_busy;
  logic [DE_ADDR_W*NUM_REQ-1:0]  in_de_addr;
  logic [DE_NBYTE_W*NUM_REQ-1:0] in_de_nbyte;
  logic [NUM_REQ-1:0]            in_de_rnw;
  logic [DE_DATA_W*NUM_REQ-1:0]  in_de_w_data;
  logic [NUM_REQ-1:0]            in_de_ack;
  logic [DE_DATA_W-1:0]          in_de_r_data;

  int n_tests = 0;
  int n_fail  = 0;

  drawing_de_if de_bus();

  drawing_de_arbiter #(.NUM_REQ(NUM_REQ)) dut (
    .clk          (clk),
    .rst          (rst),
    .in_de_req    (in_de_req),
    .in_busy      (in_busy),
    .in_de_addr   (in_de_addr),
    .in_de_nbyte  (in_de_nbyte),
    .in_de_rnw    (in_de_rnw),
    .in_de_w_data (in_de_w_data),
    .in_de_ack    (in_de_ack),
    .in_de_r_data (in_de_r_data),
    .de           (de_bus.master)
  );

  always #5 clk = ~clk;

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Requester protocol: the owning engine must keep its request up until acked
  always @(negedge clk) begin
    if (rst === 1'b0 && dut.state == GRANT && in_de_req[dut.owner] !== 1'b1) begin
      n_fail++;
      $error("FAIL protocol req_dropped observed=0 expected=1");
    end
  end

  int lock_exp [4];
  int eng0_done;
  int winner;

  initial begin
`ifdef DE_ARB_LOCK_EN
    lock_exp = '{0, 0, 0, 3};
`else
    lock_exp = '{0, 3, 0, 3};
`endif
    rst = 1'b1;
    in_de_req = '0; in_busy = '0;
    in_de_addr = '0; in_de_nbyte = '1; in_de_rnw = '1; in_de_w_data = '0;
    de_bus.de_ack = 1'b0; de_bus.de_r_data = '0;
    step; step;

    chk("rst_de_req",   de_bus.de_req,    1'b0);
    chk("rst_de_addr",  de_bus.de_addr,   18'h0);
    chk("rst_de_nbyte", de_bus.de_nbyte,  4'b1111);
    chk("rst_de_rnw",   de_bus.de_rnw,    1'b1);
    chk("rst_de_wdata", de_bus.de_w_data, 32'h0);
    chk("rst_ack",      in_de_ack,        4'b0000);
    chk("rst_ptr",      dut.ptr,          2'd0);
    rst = 1'b0;

    // single write from engine 2, ack after 3 GRANT cycles
    in_de_addr[2*18 +: 18]   = 18'h00123;
    in_de_w_data[2*32 +: 32] = 32'hDEAD_BEEF;
    in_de_nbyte[2*4 +: 4]    = 4'b0000;
    in_de_rnw[2]             = 1'b0;
    in_de_req[2]             = 1'b1;
    #1;
    chk("wr_latency_idle", de_bus.de_req, 1'b0);
    step;
    chk("wr_de_req",   de_bus.de_req,    1'b1);
    chk("wr_de_addr",  de_bus.de_addr,   18'h00123);
    chk("wr_de_wdata", de_bus.de_w_data, 32'hDEAD_BEEF);
    chk("wr_de_nbyte", de_bus.de_nbyte,  4'b0000);
    chk("wr_de_rnw",   de_bus.de_rnw,    1'b0);
    chk("wr_ack_wait", in_de_ack,        4'b0000);
    step; step;
    chk("wr_hold_req", de_bus.de_req, 1'b1);
    de_bus.de_ack = 1'b1;
    #1;
    chk("wr_ack", in_de_ack, 4'b0100);
    step;
    de_bus.de_ack = 1'b0;
    in_de_req[2]  = 1'b0;
    #1;
    chk("wr_ack_gone", in_de_ack,     4'b0000);
    chk("wr_idle_req", de_bus.de_req, 1'b0);
    chk("wr_ptr",      dut.ptr,       2'd3);

    // de_ack in IDLE must be ignored
    de_bus.de_ack = 1'b1;
    #1;
    chk("spur_ack", in_de_ack, 4'b0000);
    step;
    de_bus.de_ack = 1'b0;
    #1;
    chk("spur_req",   de_bus.de_req, 1'b0);
    chk("spur_state", dut.state,     IDLE);
    chk("spur_ptr",   dut.ptr,       2'd3);

    // read from engine 1 with broadcast read data
    in_de_addr[1*18 +: 18] = 18'h00456;
    in_de_rnw[1]           = 1'b1;
    in_de_req[1]           = 1'b1;
    step;
    chk("rd_de_req",  de_bus.de_req,  1'b1);
    chk("rd_de_addr", de_bus.de_addr, 18'h00456);
    chk("rd_de_rnw",  de_bus.de_rnw,  1'b1);
    de_bus.de_ack    = 1'b1;
    de_bus.de_r_data = 32'h1234_5678;
    #1;
    chk("rd_rdata", in_de_r_data, 32'h1234_5678);
    chk("rd_ack",   in_de_ack,    4'b0010);
    step;
    de_bus.de_ack = 1'b0;
    in_de_req[1]  = 1'b0;
    #1;
    chk("rd_ptr", dut.ptr, 2'd2);

    // reset during GRANT with engines 1 and 3 pending; ptr=2 so 3 wins
    in_de_addr[3*18 +: 18] = 18'h00789;
    in_de_req = 4'b1010;
    step;
    chk("rm_owner_addr", de_bus.de_addr, 18'h00789);
    rst = 1'b1;
    in_de_req = '0;
    de_bus.de_ack = 1'b1;
    #1;
    chk("rm_ack_discard", in_de_ack, 4'b0000);
    step;
    chk("rm_req_drop", de_bus.de_req, 1'b0);
    chk("rm_ack_none", in_de_ack,     4'b0000);
    chk("rm_ptr",      dut.ptr,       2'd0);
    de_bus.de_ack = 1'b0;
    rst = 1'b0;

    // full contention, immediate ack; first grant after reset goes to engine 0
    for (int e = 0; e < NUM_REQ; e++) begin
      in_de_addr[e*18 +: 18] = 18'h00100 + 18'(e);
      in_de_rnw[e] = 1'b1;
    end
    in_de_req = 4'b1111;
    for (int t = 0; t < 6; t++) begin
      step;
      chk($sformatf("cont_req_%0d", t),  de_bus.de_req,  1'b1);
      chk($sformatf("cont_addr_%0d", t), de_bus.de_addr, 18'h00100 + 18'(t % 4));
      de_bus.de_ack = 1'b1;
      #1;
      chk($sformatf("cont_ack_%0d", t), in_de_ack, 4'b0001 << (t % 4));
      step;
      de_bus.de_ack = 1'b0;
      #1;
      chk($sformatf("cont_gap_%0d", t), de_bus.de_req, 1'b0);
    end

    // lock scenario: engine 0 busy for three transfers, engine 3 always requesting
    rst = 1'b1;
    in_de_req = '0;
    step;
    rst = 1'b0;
    in_busy = 4'b0001;
    in_de_req = 4'b1001;
    eng0_done = 0;
    for (int t = 0; t < 4; t++) begin
      step;
      de_bus.de_ack = 1'b1;
      #1;
      chk($sformatf("lock_ack_%0d", t), in_de_ack, 4'b0001 << lock_exp[t]);
      winner = (in_de_ack == 4'b0001) ? 0 : 3;
      step;
      de_bus.de_ack = 1'b0;
      if (winner == 0) begin
        eng0_done++;
        if (eng0_done == 3) begin
          in_de_req[0] = 1'b0;
          in_busy[0]   = 1'b0;
        end
      end
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
